// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD host sequencer: FSM states, the core
// bus operand order, and the counter-width helper.
package gcd_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_CLEAR,
    S_RESP
  } state_e;

  // The core latches A on the cycle start is high, then B on the next cycle.
  typedef enum logic {
    BUS_A = 1'b0,
    BUS_B = 1'b1
  } bus_slot_e;

  localparam bus_slot_e BUS_FIRST  = BUS_A;
  localparam bus_slot_e BUS_SECOND = BUS_B;

  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/gcd_host_timer.sv
// Saturating up-counter with clear, load and enable. tc is high while the
// count sits at MAX-1; the count never wraps.
module gcd_host_timer
  import gcd_pkg::*;
#(
  parameter int MAX = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     load,
  input  logic [cnt_width(MAX)-1:0] load_val,
  output logic                     tc
);

  localparam int            CW   = cnt_width(MAX);
  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/gcd_host.sv
// Requester-side sequencer for the subtractive GCD core: loads A then B onto
// the shared bus, waits for done or timeout, clears the core, returns a result.
module gcd_host
  import gcd_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int TIMEOUT    = 1024,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy,
  output logic             core_rst_n,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             pend_q, pend_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_err_q, out_err_d;
  logic             busy_q, busy_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             core_start_q, core_start_d;
  logic [WIDTH-1:0] core_data_q, core_data_d;
  bus_slot_e        bus_slot;
  logic             wait_tc, clr_tc;

  gcd_host_timer #(.MAX(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q != S_WAIT),
    .en       ((state_q == S_WAIT) && !core_done),
    .load     (1'b0),
    .load_val ('0),
    .tc       (wait_tc)
  );

  gcd_host_timer #(.MAX(CLR_CYCLES)) u_clr_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q != S_CLEAR),
    .en       (state_q == S_CLEAR),
    .load     (1'b0),
    .load_val ('0),
    .tc       (clr_tc)
  );

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    pend_d    = pend_q;
    out_gcd_d = out_gcd_q;
    out_err_d = out_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          // A zero operand never terminates on the core, so answer locally.
          if ((in_a == '0) || (in_b == '0)) begin
            state_d   = S_RESP;
            out_gcd_d = (in_a == '0) ? in_b : in_a;
            out_err_d = (in_a == '0) && (in_b == '0);
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          out_gcd_d = core_result;
          out_err_d = 1'b0;
          pend_d    = 1'b1;
          state_d   = S_CLEAR;
        end else if (wait_tc) begin
          out_gcd_d = '0;
          out_err_d = 1'b1;
          pend_d    = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (clr_tc) begin
          state_d = pend_q ? S_RESP : S_IDLE;
          pend_d  = 1'b0;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    bus_slot     = (state_d == S_LOAD_A) ? BUS_FIRST : BUS_SECOND;
    core_data_d  = core_data_q;
    if (state_d inside {S_LOAD_A, S_LOAD_B, S_WAIT}) begin
      core_data_d = (bus_slot == BUS_A) ? a_d : b_d;
    end
    in_ready_d   = (state_d == S_IDLE);
    out_valid_d  = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
    core_rst_n_d = (state_d != S_CLEAR);
    core_start_d = (state_d == S_LOAD_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register is reset, operand latches included, so an abort discards the job.
    if (!rst_n) begin
      state_q      <= S_CLEAR;
      a_q          <= '0;
      b_q          <= '0;
      pend_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b1;
      core_rst_n_q <= 1'b0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
    end else begin
      // NOTE: non-blocking only, so every flop samples pre-edge values.
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pend_q       <= pend_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_gcd_q    <= out_gcd_d;
      out_err_q    <= out_err_d;
      busy_q       <= busy_d;
      core_rst_n_q <= core_rst_n_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_gcd    = out_gcd_q;
  assign out_err    = out_err_q;
  assign busy       = busy_q;
  assign core_rst_n = core_rst_n_q;
  assign core_start = core_start_q;
  assign core_data  = core_data_q;

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host: behavioural GCD core with programmable latency and a
// result scoreboard fed at input acceptance, drained at output handshake.
module tb_gcd_host;

  localparam int W   = 16;
  localparam int TO  = 64;
  localparam int CLR = 2;

  typedef struct {
    logic [W-1:0] gcd;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [W-1:0] in_a, in_b, out_gcd, core_data;
  logic         core_rst_n, core_start;
  logic         core_done = 1'b0;
  logic [W-1:0] core_result = '0;

  gcd_host #(.WIDTH(W), .TIMEOUT(TO), .CLR_CYCLES(CLR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .busy        (busy),
    .core_rst_n  (core_rst_n),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  logic last_fin;

  int           m_lat   = 0;
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [W-1:0] m_a = '0, m_b = '0;

  int           j_wait, j_start, j_clr, j_bus, j_d2v;
  logic [W-1:0] j_d0, j_d1;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // The host first sees done with its timer at lat+1; it must be <= TO-1.
  function automatic exp_t expect_of(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    exp_t x;
    if (a == 0 && b == 0) begin
      x.gcd = '0; x.err = 1'b1;
    end else if (a == 0 || b == 0) begin
      x.gcd = gcd_ref(a, b); x.err = 1'b0;
    end else if (lat < 0 || lat + 1 > TO - 1) begin
      x.gcd = '0; x.err = 1'b1;
    end else begin
      x.gcd = gcd_ref(a, b); x.err = 1'b0;
    end
    return x;
  endfunction

  // Behavioural core: latch A on start, B next cycle, done after m_lat cycles.
  always @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      m_phase     <= 0;
      m_cnt       <= 0;
      core_done   <= 1'b0;
      core_result <= '0;
    end else begin
      case (m_phase)
        0: if (core_start) begin m_a <= core_data; m_phase <= 1; end
        1: begin m_b <= core_data; m_phase <= 2; end
        2: begin
          if (m_lat >= 0 && m_cnt == m_lat) begin
            core_done   <= 1'b1;
            core_result <= gcd_ref(m_a, m_b);
            m_phase     <= 3;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    logic         fin, fout, e;
    logic [W-1:0] g;
    exp_t         x;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    g    = out_gcd;
    e    = out_err;
    if (fin) sb.push_back(expect_of(in_a, in_b, m_lat));
    if (fout) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("out_gcd", g, x.gcd);
        check("out_err", e, x.err);
      end
    end
    last_fin = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    tick();
    check("rel1_core_rst_n", core_rst_n, 0);
    check("rel1_in_ready", in_ready, 0);
    tick();
    check("rel2_core_rst_n", core_rst_n, 1);
    check("rel2_in_ready", in_ready, 1);
    check("rel2_out_valid", out_valid, 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    m_lat    = lat;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    last_fin = 1'b0;
    for (int k = 0; k < 20 && !last_fin; k++) tick();
    if (!last_fin) check("accept", in_ready, 1);
    in_valid = 1'b0;
  endtask

  // Accept one pair, then watch until out_valid, gathering timing statistics.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    int done_at;
    send(a, b, lat);
    j_wait = 0; j_start = 0; j_clr = 0; j_bus = 0; j_d2v = -1;
    j_d0 = '0; j_d1 = '0;
    done_at = -1;
    for (int n = 0; n < 400; n++) begin
      if (n == 0) j_d0 = core_data;
      if (n == 1) j_d1 = core_data;
      if (core_start) j_start++;
      if (!core_rst_n) j_clr++;
      if (core_done && done_at < 0) done_at = j_wait;
      if (core_rst_n && busy && !core_start && !out_valid && j_start > 0) j_bus++;
      if (out_valid) break;
      tick();
      j_wait++;
    end
    if (!out_valid) check("valid_timeout", out_valid, 1);
    if (done_at >= 0) j_d2v = j_wait - done_at;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    last_fin  = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_data", core_data, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_busy", busy, 1);
    release_reset();

    // Normal job through the core.
    run_job(16'd48, 16'd18, 20);
    check("t2_bus_a", j_d0, 48);
    check("t2_bus_b", j_d1, 18);
    check("t2_start_cycles", j_start, 1);
    check("t2_core_a", m_a, 48);
    check("t2_core_b", m_b, 18);
    check("t2_clear_cycles", j_clr, CLR);
    check("t2_done_to_valid", j_d2v, CLR + 1);
    tick();

    // Zero-operand bypass.
    run_job(16'd0, 16'd35, 5);
    check("byp1_latency", j_wait, 0);
    check("byp1_start", j_start, 0);
    check("byp1_clear", j_clr, 0);
    tick();
    run_job(16'd21, 16'd0, 5);
    check("byp2_latency", j_wait, 0);
    check("byp2_start", j_start, 0);
    tick();
    run_job(16'd0, 16'd0, 5);
    check("byp3_latency", j_wait, 0);
    check("byp3_clear", j_clr, 0);
    tick();

    // Core hangs: timeout, then a normal job afterwards.
    run_job(16'd7, 16'd5, -1);
    check("to_loadb_wait_cycles", j_bus, TO + 1);
    check("to_clear_cycles", j_clr, CLR);
    tick();
    run_job(16'd9, 16'd6, 3);
    tick();

    // Done exactly at the last timer value wins; one cycle later times out.
    run_job(16'd30, 16'd12, TO - 2);
    check("edge_clear_cycles", j_clr, CLR);
    tick();
    run_job(16'd30, 16'd12, TO - 1);
    check("late_clear_cycles", j_clr, CLR);
    tick();

    // Backpressure with a second pair waiting.
    out_ready = 1'b0;
    run_job(16'd100, 16'd75, 3);
    in_a     = 16'd12;
    in_b     = 16'd8;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_gcd", out_gcd, 25);
      check("bp_pending", sb.size(), 1);
    end
    out_ready = 1'b1;
    tick();
    run_job(16'd12, 16'd8, 3);
    tick();

    // Reset in the middle of WAIT discards the job.
    send(16'd5, 16'd3, -1);
    for (int k = 0; k < 10; k++) tick();
    check("midwait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_core_rst_n", core_rst_n, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    sb.delete();
    tick();
    release_reset();

    run_job(16'd48, 16'd18, 2);
    tick();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gcd_host.md
Name: gcd_host

Overview:
- Requester-side sequencer for the subtractive GCD engine (gcd control unit plus datapath, "the core").
- Accepts operand pairs over a valid/ready stream and loads them onto the core's shared data bus in the core's fixed order: A with start, then B.
- Waits for core done, captures the result, returns the core to its idle state through a local reset pulse, and presents the result downstream.
- Shields the core from zero operands, which would never terminate, and from hangs, via a timeout.

Parameters:
- WIDTH, 16, operand/result width in bits.
- TIMEOUT, 1024, max cycles spent in WAIT before aborting (>=2).
- CLR_CYCLES, 2, cycles core_rst_n is held low per clear (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  host can accept a pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_gcd  out  WIDTH  result.
- out_err  out  1  result invalid (timeout, or both operands zero).
- busy  out  1  job in flight (any state except IDLE).
- core_rst_n  out  1  local active-low reset to core.
- core_start  out  1  start strobe to core.
- core_data  out  WIDTH  shared operand bus to core.
- core_done  in  1  core finished (level).
- core_result  in  WIDTH  core A register.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_gcd=0, out_err=0, core_start=0, core_data=0, core_rst_n=0, busy=1.
  - Reset state is CLEAR with pend=0.
  - rst_n low at any time (including mid-job) aborts immediately; any latched job is discarded.
- All outputs are registered. in_ready=1 only in IDLE. Handshakes complete on valid&&ready at a clock edge.
- IDLE: core_rst_n=1.
  - On in_valid, latch a, b.
  - a==0 && b==0 -> RESP with gcd=0, err=1.
  - a==0 -> RESP with gcd=b. b==0 -> RESP with gcd=a.
  - Otherwise -> LOAD_A.
- LOAD_A (1 cycle): core_start=1, core_data=a -> LOAD_B.
- LOAD_B (1 cycle): core_start=0, core_data=b, timer cleared -> WAIT.
- WAIT: core_data=b.
  - core_done=1 -> capture core_result as gcd, err=0 -> CLEAR with pend=1.
  - Else timer increments; on the cycle timer==TIMEOUT-1 with no done -> gcd=0, err=1 -> CLEAR with pend=1.
  - done and expiry in the same cycle: done wins.
- CLEAR: core_rst_n=0 and core_start=0 for exactly CLR_CYCLES cycles. Then pend=1 -> RESP; pend=0 (post-reset) -> IDLE.
- RESP: out_valid=1, out_gcd/out_err stable until out_ready -> IDLE. No new pair is accepted while in RESP.
- Latency, nonzero operands:
  - Accept at edge t; core_start high in cycle t+1; B on bus in cycle t+2.
  - WAIT from t+3; done sampled at edge d; CLEAR for CLR_CYCLES cycles; out_valid from edge d+CLR_CYCLES+1.
- Latency, zero-operand bypass: out_valid one cycle after acceptance; core untouched (core_start never asserted, no clear).
- Timer width is clog2(TIMEOUT); it never wraps, because WAIT is left at TIMEOUT-1.
- core_done is ignored outside WAIT.

Decomposition:
- gcd_pkg holds: state encoding (IDLE, LOAD_A, LOAD_B, WAIT, CLEAR, RESP), default WIDTH, and the core bus ordering constants (A first, B second).
- One sub-module: gcd_host_timer, a loadable up-counter with clear, enable and terminal-count flag, parameterised by TIMEOUT; it is reused for the CLR_CYCLES count.

Test Plan:
1. Reset: assert rst_n low mid-WAIT -> core_rst_n=0 and out_valid=0 in the same cycle. Release -> core_rst_n low 2 more cycles, then in_ready=1, no out_valid.
2. a=48, b=18 with core model returning 6 after 20 cycles:
   - core_start=1 with core_data=48 for one cycle, then core_data=18.
   - core_rst_n low 2 cycles after done.
   - out_gcd=6, out_err=0.
3. Bypass cases, each with core_start held 0:
   - a=0, b=35 -> out_valid next cycle, out_gcd=35.
   - a=21, b=0 -> out_gcd=21.
   - a=0, b=0 -> out_gcd=0, out_err=1.
4. TIMEOUT=64, core never asserts done -> exactly 64 WAIT cycles, then 2 CLEAR cycles, then out_valid with out_gcd=0, out_err=1. Next pair a=9, b=6 -> out_gcd=3.
5. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid, out_gcd stable, in_ready=0, second pair not consumed until the result handshake completes.
6. core_done rises on the cycle timer==TIMEOUT-1 -> result captured, out_err=0.
